// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: access-width codes, FSM states and load extension shared by the responder
package dmem_responder_pkg;
  localparam int CNT_W = 4;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
           f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
           f3 == F3_BU ? {24'd0, s[7:0]} :
           f3 == F3_HU ? {16'd0, s[15:0]} : s;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word memory with byte-enable write and registered read
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: RV32I memory-stage responder with fixed wait states around a byte-enabled data array
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic wr_q, wr, accept, commit, err;
  logic [31:0] addr_q, wdata_q, addr, wdata, arr_wdata, arr_rdata;
  logic [2:0] f3_q, f3;
  logic [3:0] be;
  assign req_ready_o = state == IDLE;
  assign accept = req_valid_i && req_ready_o;
  // with zero wait states the array is accessed on the accept edge, straight from the request inputs
  assign wr    = state == IDLE ? req_write_i  : wr_q;
  assign addr  = state == IDLE ? req_addr_i   : addr_q;
  assign f3    = state == IDLE ? req_funct3_i : f3_q;
  assign wdata = state == IDLE ? req_wdata_i  : wdata_q;
  assign err = ((f3 == F3_H || f3 == F3_HU) && addr[0]) ||
               (f3 == F3_W && addr[1:0] != 2'd0) ||
               ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) ||
               (wr ? f3 > F3_W : (f3 == 3'd3 || f3 > F3_HU));
  assign be = f3 == F3_B ? 4'b0001 << addr[1:0] : f3 == F3_H ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign arr_wdata = f3 == F3_B ? {4{wdata[7:0]}} : f3 == F3_H ? {2{wdata[15:0]}} : wdata;
  always_comb begin
    next = state;
    commit = 1'b0;
    if (accept) begin
      next = WAIT_CYCLES == 0 ? RESP : WAIT;
      commit = WAIT_CYCLES == 0;
    end else if (state == WAIT && cnt == '0) begin
      next = RESP;
      commit = 1'b1;
    end else if (state == RESP && rsp_ready_i) next = IDLE;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
    end else begin
      state <= next;
      if (accept) begin
        cnt     <= CNT_W'(WAIT_CYCLES - 1);
        wr_q    <= req_write_i;
        addr_q  <= req_addr_i;
        f3_q    <= req_funct3_i;
        wdata_q <= req_wdata_i;
      end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end
  dmem_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk_i),
    .en(commit && !err),
    .we(wr),
    .be(be),
    .addr(addr[AW+1:2]),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );
  // the array read register only changes on a commit, so these hold steady through a stalled RESP
  assign rsp_valid_o = state == RESP;
  assign rsp_error_o = state == RESP && err;
  assign rsp_rdata_o = (state == RESP && !err && !wr) ? load_extend(arr_rdata, addr[1:0], f3) : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: random and directed accesses checked every cycle against a byte-level memory model
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int W = 2;
  logic clk_i = 1'b0, reset_i = 1'b0;
  logic req_valid_i = 1'b0, req_write_i = 1'b0, rsp_ready_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [2:0] req_funct3_i = '0;
  logic req_ready_o, rsp_valid_o, rsp_error_o;
  logic [31:0] rsp_rdata_o;
  int n_cmp = 0, n_bad = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_funct3_i(req_funct3_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [31:0] mm [DEPTH];
  logic busy = 1'b0, exp_err = 1'b0, pend_we = 1'b0;
  int age = 0;
  logic [31:0] exp_data = '0, pend_idx = '0, pend_word = '0;

  function automatic logic m_err(input logic w, input logic [31:0] a, input logic [2:0] f3);
    int sz = 1 << f3[1:0];
    if (w ? f3 > 3'd2 : (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
    if (a % sz != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
    int n = 1 << f3[1:0];
    int off = int'(a % 4);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mm[a / 4][8*(off + k) +: 8];
    if (!f3[2] && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    int n = 1 << f3[1:0];
    int off = int'(a % 4);
    logic [31:0] word = mm[a / 4];
    for (int k = 0; k < n; k++) word[8*(off + k) +: 8] = wd[8*k +: 8];
    return word;
  endfunction

  // model: response due W+1 cycles after accept; store lands on the edge into the response cycle
  always @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      busy <= 1'b0;
      age  <= 0;
    end else if (!busy) begin
      if (req_valid_i) begin
        busy      <= 1'b1;
        age       <= 1;
        exp_err   <= m_err(req_write_i, req_addr_i, req_funct3_i);
        exp_data  <= (req_write_i || m_err(req_write_i, req_addr_i, req_funct3_i)) ? 32'd0 : m_load(req_addr_i, req_funct3_i);
        pend_we   <= req_write_i && !m_err(req_write_i, req_addr_i, req_funct3_i);
        pend_idx  <= req_addr_i / 4;
        pend_word <= m_err(req_write_i, req_addr_i, req_funct3_i) ? 32'd0 : m_store(req_addr_i, req_funct3_i, req_wdata_i);
        if (W == 0 && req_write_i && !m_err(req_write_i, req_addr_i, req_funct3_i))
          mm[req_addr_i / 4] <= m_store(req_addr_i, req_funct3_i, req_wdata_i);
      end
    end else if (age <= W) begin
      age <= age + 1;
      if (age == W && pend_we) mm[pend_idx] <= pend_word;
    end else if (rsp_ready_i) busy <= 1'b0;

  always @(negedge clk_i)
    if (!reset_i) begin
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
      chk("rst_rsp_error", 32'(rsp_error_o), 32'd0);
      chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    end else begin
      chk("req_ready", 32'(req_ready_o), 32'(!busy));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(busy && age == W + 1));
      if (busy && age == W + 1) begin
        chk("rsp_rdata", rsp_rdata_o, exp_data);
        chk("rsp_error", 32'(rsp_error_o), 32'(exp_err));
      end
    end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                        input int stall, output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    rd = '0;
    er = 1'b0;
    lat = 0;
    req_write_i = w;
    req_addr_i = a;
    req_funct3_i = f3;
    req_wdata_i = wd;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1;
    req_valid_i = 1'($urandom);
    req_write_i = 1'($urandom);
    req_addr_i = $urandom;
    req_funct3_i = 3'($urandom);
    req_wdata_i = $urandom;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!rsp_valid_o && lat < 40);
    if (!rsp_valid_o) begin
      chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
      req_valid_i = 1'b0;
      return;
    end
    rd = rsp_rdata_o;
    er = rsp_error_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk("stall_valid", 32'(rsp_valid_o), 32'd1);
      chk("stall_rdata", rsp_rdata_o, rd);
      chk("stall_error", 32'(rsp_error_o), 32'(er));
      chk("stall_ready", 32'(req_ready_o), 32'd0);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(4*i), 3'd2, $urandom, 0, rd, er, lat);
    do_req(1'b1, 32'h0, 3'd2, 32'hCAFE_F00D, 0, rd, er, lat);
    do_req(1'b1, 32'h20, 3'd2, 32'hA5A5_0F0F, 0, rd, er, lat);
    do_req(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 0, rd, er, lat);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_error", 32'(er), 32'd0);
    chk("sw_latency", 32'(lat), 32'd3);
    do_req(1'b0, 32'h10, 3'd2, 0, 0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEAD_BEEF);
    chk("lw_error", 32'(er), 32'd0);
    chk("lw_latency", 32'(lat), 32'd3);
    do_req(1'b0, 32'h13, 3'd0, 0, 0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 32'h13, 3'd4, 0, 0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h0000_00DE);
    do_req(1'b0, 32'h10, 3'd1, 0, 0, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFF_BEEF);
    do_req(1'b0, 32'h12, 3'd5, 0, 0, rd, er, lat);
    chk("lhu_rdata", rd, 32'h0000_DEAD);
    do_req(1'b1, 32'h11, 3'd0, 32'h0000_0055, 0, rd, er, lat);
    do_req(1'b0, 32'h10, 3'd2, 0, 0, rd, er, lat);
    chk("sb_then_lw", rd, 32'hDEAD_55EF);
    do_req(1'b0, 32'h12, 3'd2, 0, 0, rd, er, lat);
    chk("lw_misalign_error", 32'(er), 32'd1);
    chk("lw_misalign_rdata", rd, 32'd0);
    do_req(1'b1, 32'(4*DEPTH), 3'd2, 32'h1234_5678, 0, rd, er, lat);
    chk("sw_range_error", 32'(er), 32'd1);
    do_req(1'b0, 32'h0, 3'd2, 0, 0, rd, er, lat);
    chk("word0_unchanged", rd, 32'hCAFE_F00D);
    do_req(1'b0, 32'h10, 3'd2, 0, 5, rd, er, lat);
    chk("stalled_lw_rdata", rd, 32'hDEAD_55EF);
    req_write_i = 1'b1;
    req_addr_i = 32'h20;
    req_funct3_i = 3'd2;
    req_wdata_i = 32'h1111_1111;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    chk("midwait_rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("midwait_rst_ready", 32'(req_ready_o), 32'd1);
    chk("midwait_rst_rdata", rsp_rdata_o, 32'd0);
    chk("midwait_rst_error", 32'(rsp_error_o), 32'd0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    do_req(1'b0, 32'h20, 3'd2, 0, 0, rd, er, lat);
    chk("abandoned_store", rd, 32'hA5A5_0F0F);
    for (int i = 0; i < 400; i++)
      do_req(1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 3)),
             3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), rd, er, lat);
    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words of data memory.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  1  memory-stage request valid.
REQ-006 req_ready_o  output  1  responder can accept a request.
REQ-007 req_write_i  input  1  1 = store, 0 = load.
REQ-008 req_addr_i  input  32  byte address (ALU result).
REQ-009 req_funct3_i  input  3  RV32I access width/sign code.
REQ-010 req_wdata_i  input  32  store data (rs2 value), LSB-aligned.
REQ-011 rsp_valid_o  output  1  response valid.
REQ-012 rsp_ready_i  input  1  requester accepts response.
REQ-013 rsp_rdata_o  output  32  load data, extended per funct3.
REQ-014 rsp_error_o  output  1  access fault (misaligned, out of range, illegal funct3).

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 IDLE: req_valid_i & req_ready_o latches write, addr, funct3, wdata; next state WAIT, or RESP when WAIT_CYCLES = 0.
REQ-017 WAIT: counter loads WAIT_CYCLES-1 on accept, decrements each cycle; at 0 the next state is RESP.
REQ-018 Accept-to-rsp_valid_o latency SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-019 RESP: rsp_valid_o = 1; rsp_rdata_o and rsp_error_o stable until rsp_valid_o & rsp_ready_i, then IDLE.
REQ-020 No new request is accepted in the cycle a response completes; back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-021 Loads: funct3 0 LB sign-extend, 1 LH sign-extend, 2 LW, 4 LBU zero-extend, 5 LHU zero-extend; byte lane from addr[1:0].
REQ-022 Stores: funct3 0 SB, 1 SH, 2 SW; byte-enables from addr[1:0]; wdata replicated to the selected lanes.
REQ-023 Store array update SHALL occur on the WAIT->RESP (or IDLE->RESP) transition edge, exactly once per request.
REQ-024 Load data SHALL be sampled from the array on that same edge and registered into rsp_rdata_o.
REQ-025 Error if halfword with addr[0]=1, word with addr[1:0]!=0, addr[31:2] >= DEPTH_WORDS, load funct3 in {3,6,7}, or store funct3 > 2.
REQ-026 On error: no array write, rsp_rdata_o = 0, rsp_error_o = 1; the FSM still completes normally.
REQ-027 Store responses return rsp_rdata_o = 0.
REQ-028 Request inputs are ignored outside IDLE; a deasserted rsp_ready_i stalls indefinitely without loss.

Reset
REQ-029 reset_i low: state IDLE, counter 0, req_ready_o = 1 after release, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_error_o = 0.
REQ-030 Reset mid-WAIT abandons the request with no array write; a store already committed in RESP is retained.
REQ-031 Memory array contents are not reset.

Structure
REQ-032 Shared package holds funct3 load/store constants, FSM state typedef, and the WAIT counter width constant.
REQ-033 Sub-module dmem_array holds the single-port DEPTH_WORDS x 32 array with 4-bit byte-enable write and synchronous read.
REQ-034 dmem_responder holds the FSM, counter, alignment/range checks, lane steering, and extension.

Verification
REQ-035 Store word 0xDEADBEEF at addr 0x10, then LW 0x10 -> rsp_rdata_o = 0xDEADBEEF, rsp_error_o = 0, rsp_valid_o 3 cycles after each accept (WAIT_CYCLES=2).
REQ-036 After that, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-037 SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF.
REQ-038 LW 0x12 -> rsp_error_o = 1, rsp_rdata_o = 0; SW to addr 4*DEPTH_WORDS -> error, and a subsequent LW of word 0 is unchanged.
REQ-039 Hold rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o and rsp_rdata_o held constant, req_ready_o = 0 throughout.
REQ-040 Assert reset_i low during WAIT of SW 0x11111111 to 0x20 -> all outputs reset immediately; a later LW 0x20 returns the prior contents.
